// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for a single-bit enabled
// capture flop. A word taken over valid/ready is presented one bit at a
// time on ser_din, with a one-cycle ser_en strobe at the start of every
// DIV-clock bit period. All outputs decode from registered state only.

module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter int DIV       = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_din,
   output logic             ser_en,
   output logic             busy,
   output logic             done
);

   // A one-clock bit period still needs a 1-bit divider so the compare
   // below stays legal; it simply never leaves zero.
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH) + 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q,   state_d;
   logic [WIDTH-1:0] shreg_q,   shreg_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shreg_shifted;

   // Move the word one place toward whichever end feeds ser_din, zero-filled.
   always_comb begin
      shreg_shifted = '0;
      if (MSB_FIRST != 0) begin
         shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
         shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      end
   end

   // Next-state logic: load on accept, step the bit-period divider, advance
   // one bit per period and finish with a single DONE cycle.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               shreg_d   = in_data;
               div_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               shreg_d   = shreg_shifted;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = DONE;
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; synchronous reset wins over an accept in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Output decode from registered state only, so no input reaches an output
   // without passing through a flop.
   always_comb begin
      in_ready = 1'b0;
      ser_din  = 1'b0;
      ser_en   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         SHIFT: begin
            busy    = 1'b1;
            ser_en  = (div_cnt_q == '0);
            ser_din = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule
